// File: rtl/echo_capture.sv
// echo_capture: trigger-gated ADC frame capture feeding a 16-entry first-word-fall-through FIFO.
// Frames carry sof/eof markers; FIFO overflow and triggers arriving while busy raise sticky flags.
module echo_capture #(
   parameter int DATA_W = 10,
   parameter int LEN_W  = 12
) (
   input  logic              i_clk100M,
   input  logic              rst,
   input  logic              en,
   input  logic              trig,
   input  logic [19:0]       delay,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              o_ready,
   output logic              o_sof,
   output logic              o_eof,
   output logic              busy,
   output logic              ovf,
   output logic              miss,
   output logic [15:0]       frame_cnt
);
   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int CW      = AW + 1;
   localparam int ENTRY_W = DATA_W + 2;

   typedef enum logic [1:0] {IDLE, DELAY, CAPTURE} state_t;

   state_t             state_q, state_d;
   logic               trig_prev_q, trig_prev_d;
   logic [19:0]        dcnt_q, dcnt_d;
   logic [LEN_W-1:0]   lcnt_q, lcnt_d;
   logic               first_q, first_d;
   logic               ovf_q, ovf_d;
   logic               miss_q, miss_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic               trig_edge;
   logic               last_sample;
   logic               wr_req;
   logic               wr_en;
   logic               rd_fire;
   logic               full;
   logic               fifo_drop;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;

   assign trig_edge   = trig & ~trig_prev_q & en;
   assign last_sample = (lcnt_q == LEN_W'(1));

   always_ff @(posedge i_clk100M or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         trig_prev_q <= 1'b1;
         dcnt_q      <= '0;
         lcnt_q      <= '0;
         first_q     <= 1'b0;
         ovf_q       <= 1'b0;
         miss_q      <= 1'b0;
         frame_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         trig_prev_q <= trig_prev_d;
         dcnt_q      <= dcnt_d;
         lcnt_q      <= lcnt_d;
         first_q     <= first_d;
         ovf_q       <= ovf_d;
         miss_q      <= miss_d;
         frame_cnt_q <= frame_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (trig_edge && (length != '0))
                  state_d = (delay == 20'd0) ? CAPTURE : DELAY;
            end
            DELAY: begin
               if (dcnt_q == 20'd1)
                  state_d = CAPTURE;
            end
            CAPTURE: begin
               if (last_sample)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      trig_prev_d = trig;
      dcnt_d      = dcnt_q;
      lcnt_d      = lcnt_q;
      first_d     = first_q;
      ovf_d       = ovf_q;
      miss_d      = miss_q;
      frame_cnt_d = frame_cnt_q;
      wr_req      = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (trig_edge) begin
                  dcnt_d  = delay;
                  lcnt_d  = length;
                  first_d = 1'b1;
                  // A zero-length frame is complete the moment its edge is accepted.
                  if (length == '0)
                     frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end
            DELAY: begin
               dcnt_d = dcnt_q - 20'd1;
               if (trig_edge)
                  miss_d = 1'b1;
            end
            CAPTURE: begin
               wr_req  = 1'b1;
               lcnt_d  = lcnt_q - LEN_W'(1);
               first_d = 1'b0;
               if (last_sample)
                  frame_cnt_d = frame_cnt_q + 16'd1;
               if (trig_edge)
                  miss_d = 1'b1;
            end
            default: ;
         endcase
         if (fifo_drop)
            ovf_d = 1'b1;
      end else begin
         ovf_d  = 1'b0;
         miss_d = 1'b0;
      end
   end

   assign full      = (count_q == CW'(DEPTH));
   assign rd_fire   = o_valid & o_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign wr_en     = wr_req & (~full | rd_fire);
   assign fifo_drop = wr_req & full & ~rd_fire;
   assign wr_entry  = {adc_data, first_q, last_sample};

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_fire);
      count_d  = count_q + CW'(wr_en) - CW'(rd_fire);
      if (!en) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
         always_ff @(posedge i_clk100M) begin
            if (wr_en && (wr_ptr_q == AW'(gi)))
               mem_q[gi] <= wr_entry;
         end
      end
   endgenerate

   // Head is read asynchronously so a write into an empty FIFO shows one clock later.
   assign head      = mem_q[rd_ptr_q];
   assign o_valid   = (count_q != '0);
   assign o_data    = o_valid ? head[ENTRY_W-1:2] : '0;
   assign o_sof     = o_valid & head[1];
   assign o_eof     = o_valid & head[0];
   assign busy      = (state_q != IDLE);
   assign ovf       = ovf_q;
   assign miss      = miss_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_echo_capture.sv
// Self-checking bench for echo_capture: random delays, lengths, ADC data and o_ready
// checked against a frame-level model built from the recorded ADC history.
module tb_echo_capture;
   localparam int DATA_W = 10;
   localparam int LEN_W  = 12;
   localparam int INF    = 1 << 30;

   logic              i_clk100M = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              trig = 1'b0;
   logic              o_ready = 1'b0;
   logic [19:0]       delay = '0;
   logic [LEN_W-1:0]  length = '0;
   logic [DATA_W-1:0] adc_data = '0;
   logic [DATA_W-1:0] o_data;
   logic              o_valid, o_sof, o_eof, busy, ovf, miss;
   logic [15:0]       frame_cnt;

   echo_capture #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .i_clk100M (i_clk100M),
      .rst       (rst),
      .en        (en),
      .trig      (trig),
      .delay     (delay),
      .length    (length),
      .adc_data  (adc_data),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_sof     (o_sof),
      .o_eof     (o_eof),
      .busy      (busy),
      .ovf       (ovf),
      .miss      (miss),
      .frame_cnt (frame_cnt)
   );

   always #5 i_clk100M = ~i_clk100M;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge i_clk100M) cyc <= cyc + 1;

   // adc_log[n] is the sample the DUT sees at clock edge n
   logic [DATA_W-1:0] adc_log [int];
   initial forever begin
      @(negedge i_clk100M);
      adc_data = DATA_W'($urandom);
      adc_log[cyc + 1] = adc_data;
   end

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sof;
      logic              eof;
   } beat_t;
   beat_t got_q[$];

   initial forever begin
      @(negedge i_clk100M);
      #4;
      if (!rst && en && o_valid && o_ready)
         got_q.push_back('{o_data, o_sof, o_eof});
   end

   bit chk_on = 1'b0;
   bit rand_ready = 1'b0;
   int busy_lo = 1, busy_hi = 0;
   int ovf_at = INF, miss_at = INF;
   int exp_frames = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge i_clk100M);
      if (rand_ready) o_ready = 1'($urandom_range(0, 1));
      if (chk_on) begin
         check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
         check("ovf",  32'(ovf),  32'(cyc >= ovf_at));
         check("miss", 32'(miss), 32'(cyc >= miss_at));
      end
   endtask

   task automatic run_until(input int target);
      while (cyc < target) step();
   endtask

   task automatic fire(input int d, input int len, output int e0);
      delay   = 20'(d);
      length  = LEN_W'(len);
      trig    = 1'b1;
      e0      = cyc + 1;
      busy_lo = e0;
      busy_hi = (len == 0) ? e0 - 1 : e0 + d + len - 1;
      step();
      trig = 1'b0;
   endtask

   task automatic drain(input int n, input int budget);
      rand_ready = 1'b0;
      o_ready    = 1'b1;
      for (int t = 0; t < budget && got_q.size() < n; t++) step();
      repeat (2) step();
   endtask

   task automatic compare_frame(input int e0, input int d, input int len, input int nkeep);
      check("beats", 32'(got_q.size()), 32'(nkeep));
      for (int k = 0; k < nkeep && k < got_q.size(); k++) begin
         check("data", 32'(got_q[k].data), 32'(adc_log[e0 + 1 + d + k]));
         check("sof",  32'(got_q[k].sof),  32'(k == 0));
         check("eof",  32'(got_q[k].eof),  32'(k == len - 1));
      end
      $display("frame e0=%0d delay=%0d length=%0d beats=%0d", e0, d, len, got_q.size());
      got_q.delete();
   endtask

   initial begin
      int e0, e1, d, len;

      rst = 1'b1;
      repeat (3) @(negedge i_clk100M);
      check("rst_o_valid",   32'(o_valid),   32'd0);
      check("rst_o_data",    32'(o_data),    32'd0);
      check("rst_o_sof",     32'(o_sof),     32'd0);
      check("rst_o_eof",     32'(o_eof),     32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_ovf",       32'(ovf),       32'd0);
      check("rst_miss",      32'(miss),      32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      step();
      step();
      chk_on = 1'b1;

      // basic frame
      o_ready = 1'b1;
      fire(5, 4, e0);
      run_until(e0 + 5 + 4 + 1);
      drain(4, 50);
      compare_frame(e0, 5, 4, 4);
      exp_frames++;
      check("frame_cnt_basic", 32'(frame_cnt), 32'(exp_frames));

      // random frames with random backpressure (never more than 16 queued)
      for (int i = 0; i < 6; i++) begin
         d   = $urandom_range(0, 12);
         len = $urandom_range(1, 16);
         rand_ready = 1'b1;
         fire(d, len, e0);
         run_until(e0 + d + len + 1);
         drain(len, 100);
         compare_frame(e0, d, len, len);
         exp_frames++;
         check("frame_cnt_rand", 32'(frame_cnt), 32'(exp_frames));
      end

      // zero delay, then zero length
      fire(0, 2, e0);
      run_until(e0 + 4);
      drain(2, 50);
      compare_frame(e0, 0, 2, 2);
      exp_frames++;
      check("frame_cnt_d0", 32'(frame_cnt), 32'(exp_frames));
      d = $urandom_range(0, 9);
      fire(d, 0, e0);
      run_until(e0 + d + 6);
      check("len0_beats", 32'(got_q.size()), 32'd0);
      exp_frames++;
      check("frame_cnt_len0", 32'(frame_cnt), 32'(exp_frames));
      $display("zero-length frame e0=%0d frame_cnt=%0d", e0, frame_cnt);

      // overflow: 20 samples into a stalled 16-entry FIFO
      o_ready = 1'b0;
      d = $urandom_range(1, 8);
      fire(d, 20, e0);
      ovf_at = e0 + 1 + d + 16;
      run_until(e0 + d + 22);
      exp_frames++;
      check("frame_cnt_ovf", 32'(frame_cnt), 32'(exp_frames));
      for (int t = 0; t < 3; t++) begin
         check("hold_valid", 32'(o_valid), 32'd1);
         check("hold_data",  32'(o_data),  32'(adc_log[e0 + 1 + d]));
         check("hold_sof",   32'(o_sof),   32'd1);
         step();
      end
      drain(16, 60);
      compare_frame(e0, d, 20, 16);

      // clear sticky flags with an enable pulse
      o_ready = 1'b0;
      ovf_at  = INF;
      en      = 1'b0;
      step();
      en = 1'b1;
      step();

      // full FIFO with a read in the same cycle as the 17th write
      d = $urandom_range(0, 5);
      fire(d, 30, e0);
      run_until(e0 + d + 16);
      check("full_valid", 32'(o_valid), 32'd1);
      o_ready = 1'b1;
      run_until(e0 + d + 31);
      drain(30, 60);
      compare_frame(e0, d, 30, 30);
      exp_frames++;
      check("frame_cnt_full", 32'(frame_cnt), 32'(exp_frames));

      // retrigger during a long delay
      len = $urandom_range(1, 10);
      fire(100, len, e0);
      run_until(e0 + 20);
      trig    = 1'b1;
      e1      = cyc + 1;
      miss_at = e1;
      step();
      trig = 1'b0;
      run_until(e0 + 100 + len + 1);
      drain(len, 50);
      compare_frame(e0, 100, len, len);
      exp_frames++;
      check("frame_cnt_retrig", 32'(frame_cnt), 32'(exp_frames));

      // abort mid-capture with 3 samples queued, miss still set
      o_ready = 1'b0;
      d = $urandom_range(0, 5);
      fire(d, 40, e0);
      run_until(e0 + d + 3);
      check("abort_pre_valid", 32'(o_valid), 32'd1);
      check("abort_pre_busy",  32'(busy),    32'd1);
      chk_on = 1'b0;
      en     = 1'b0;
      step();
      check("abort_valid",     32'(o_valid),   32'd0);
      check("abort_busy",      32'(busy),      32'd0);
      check("abort_ovf",       32'(ovf),       32'd0);
      check("abort_miss",      32'(miss),      32'd0);
      check("abort_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      check("abort_beats",     32'(got_q.size()), 32'd0);
      $display("abort e0=%0d frame_cnt=%0d", e0, frame_cnt);
      rst = 1'b1;
      step();
      check("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
      rst = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
